issue_select_scheduler: RTL and testbench
=========================================

// Module: issue_select_scheduler
// PURPOSE
//  Round-robin select scheduler for one issue lane. Each cycle it grants at most one of N requesting issue-queue entries to the lane's functional unit (FU).
//  It replaces fixed lowest-index priority with a rotating pointer. It also sequences non-pipelined multi-cycle FUs by holding off new grants while the FU is occupied.
//  Sits between issue-queue wakeup/ready logic and the FU's payload-read stage.
// PARAMETERS
//  NUM_REQ   16  number of requesting issue-queue entries (any value >= 2, not restricted to powers of 2)
//  LAT_W      3  width of per-entry FU occupancy field; occupancy is 1..2^LAT_W-1 cycles
//  AGE_W      4  width of per-entry starvation counter (used only with SELECT_AGING_EN)
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high reset
//  req_i          in   NUM_REQ             per-entry ready-to-issue request
//  lat_i          in   NUM_REQ*LAT_W       per-entry FU occupancy; entry k occupies bits [k*LAT_W +: LAT_W]; 0 is treated as 1
//  fu_ready_i     in   1                   FU can accept an op this cycle (external back-pressure)
//  flush_i        in   1                   pipeline flush; aborts occupancy, blocks grant this cycle
//  grant_o        out  NUM_REQ             one-hot grant, combinational from req_i and registered state
//  grant_valid_o  out  1                   |grant_o; op is issued this cycle
//  grant_idx_o    out  $clog2(NUM_REQ)     binary index of granted entry; 0 when !grant_valid_o
//  busy_o         out  1                   FU occupied by a multi-cycle op (state BUSY)
// BEHAVIOUR
//  - Reset state: ptr=0, state=READY, cnt=0, all age counters 0. While reset is high: grant_o=0, grant_valid_o=0, grant_idx_o=0, busy_o=0.
//  - Grant condition: state==READY && fu_ready_i && !flush_i && |req_i. Otherwise grant_o=0.
//  - Pick rule: the first requesting entry at index >= ptr, searching upward and wrapping from NUM_REQ-1 to 0.
//  - Grant latency: 0 cycles (same cycle as req_i). All state updates happen on the next clk edge.
//  - On a grant to entry w: ptr <= (w==NUM_REQ-1) ? 0 : w+1. ptr is unchanged in any cycle without a grant.
//  - States:
//     READY: on a grant with L=max(lat_i[w],1): if L==1, stay READY; else go to BUSY with cnt <= L-1.
//     BUSY: busy_o=1 and no grants. Each cycle cnt <= cnt-1. When cnt==1, go to READY next cycle.
//       An op of occupancy L therefore permits the next grant exactly L cycles after its own grant.
//     flush_i (any state): next state=READY, cnt<=0. ptr is unchanged. Grant is suppressed in the flush cycle.
//  - fu_ready_i low only blocks grants. It does not stall the BUSY countdown.
//  - req_i de-asserting mid-BUSY has no effect on the countdown.
//  - reset high mid-BUSY: next cycle is READY, ptr=0.
// CONFIGURATION
//  SELECT_AGING_EN defined:
//    - Per-entry counter age[k] increments (saturating at 2^AGE_W-1) each cycle that req_i[k]=1 and the entry is not granted.
//    - age[k] clears on its own grant, or when req_i[k]=0.
//    - Starved entries are those with age == 2^AGE_W-1. If any starved entry requests, the pick is the lowest-index starved entry, overriding ptr.
//    - ptr updates normally from w.
//  SELECT_AGING_EN undefined: no age counters are instantiated; the pick is pure round-robin.
// STRUCTURE
//  - Package issue_sched_pkg holds:
//     typedef enum logic {SCHED_READY, SCHED_BUSY} sched_state_t;
//     localparam LAT_ONE = 1 (the minimum-occupancy constant).
//  - Sub-module issue_rr_pick (combinational):
//     inputs req and ptr; outputs one-hot grant and binary index.
//     Implementation: mask req by ptr, priority-encode the masked vector, fall back to the unmasked vector if the masked vector is empty.
//     Also instantiated for the starved-vector pick when SELECT_AGING_EN is defined.
//  - The top level holds the FSM, cnt, ptr, age counters and output gating.
// TESTING
//  1. Fairness:
//     - Stimulus: after reset, req_i=16'hFFFF with all lat=1, fu_ready_i=1, held for 20 cycles.
//     - Required: grant_idx_o = 0,1,...,15,0,1,2,3 (wrap from 15 to 0).
//  2. Sparse wrap:
//     - Stimulus: req_i=16'h8001 held, ptr starts at 0.
//     - Required: grants 0,15,0,15,... and ptr alternates between 1 and 0.
//  3. Multi-cycle occupancy:
//     - Stimulus: req_i=16'h0006, lat[1]=3, lat[2]=1.
//     - Required: grant 1 at cycle t; busy_o=1 at t+1 and t+2; grant 2 at t+3.
//     - Sub-case lat=0: must behave exactly as lat=1.
//  4. Back-pressure and flush:
//     - Stimulus: fu_ready_i=0 for 3 cycles with req_i=16'h0010.
//     - Required: no grants and ptr unchanged; grant 4 in the cycle fu_ready_i returns to 1.
//     - Stimulus: flush_i=1 during BUSY with cnt=2.
//     - Required: the next cycle is READY, and a grant is possible in that cycle.
//  5. Aging (SELECT_AGING_EN defined, AGE_W=2):
//     - Stimulus: entry 3 requests continuously.
//     - Stimulus: entries 0-2 request in a pattern that keeps ptr from ever reaching 3.
//     - Required: entry 3 is granted within 4 cycles of its first request, and age[3]=0 afterwards.
//  6. Reset mid-operation:
//     - Stimulus: assert reset with busy_o=1 and ptr=7.
//     - Required: next cycle ptr=0, busy_o=0; with req_i=16'hFFFF the next grant is 0.

Source files
------------

// File: rtl/issue_sched_pkg.sv
// Shared types and constants for the issue-lane select scheduler.
package issue_sched_pkg;

    typedef enum logic {SCHED_READY, SCHED_BUSY} sched_state_t;

    // Minimum FU occupancy; an occupancy field of 0 is promoted to this.
    localparam int LAT_ONE = 1;

endpackage

// File: rtl/issue_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping to the lowest set bit when nothing at or above ptr is requesting.
module issue_rr_pick #(
    parameter  int NUM_REQ = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] sel;
    logic               found;

    // Keep only requests at or above the pointer; fall back to all requests.
    always_comb begin
        masked = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            masked[k] = req[k] && (IDX_W'(k) >= ptr);
        end
        sel = (|masked) ? masked : req;
    end

    // Lowest-index priority encode of the selected vector.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel[k] && !found) begin
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select_scheduler.sv
// Round-robin select scheduler for one issue lane. Grants at most one
// requesting entry per cycle and holds off grants while a multi-cycle
// FU op is in flight. Optional starvation aging: define SELECT_AGING_EN.
module issue_select_scheduler
    import issue_sched_pkg::*;
#(
    parameter  int NUM_REQ = 16,
    parameter  int LAT_W   = 3,
    parameter  int AGE_W   = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*LAT_W-1:0] lat_i,
    input  logic                     fu_ready_i,
    input  logic                     flush_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     grant_valid_o,
    output logic [IDX_W-1:0]         grant_idx_o,
    output logic                     busy_o
);

    sched_state_t       state_q;
    logic [LAT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;

    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_en;
    logic [LAT_W-1:0]   occ;

    // An occupancy field of zero behaves as a single-cycle op.
    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] l);
        return (l == '0) ? LAT_W'(LAT_ONE) : l;
    endfunction

    issue_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

`ifdef SELECT_AGING_EN
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0]   age_q [NUM_REQ];
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] st_grant;
    logic [IDX_W-1:0]   st_idx;

    // Requesting entries whose counter has saturated.
    always_comb begin
        starved = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            starved[k] = req_i[k] && (age_q[k] == AGE_MAX);
        end
    end

    // Pointer fixed at 0 gives lowest-index-first among starved entries.
    issue_rr_pick #(.NUM_REQ(NUM_REQ)) u_starved_pick (
        .req   (starved),
        .ptr   ('0),
        .grant (st_grant),
        .idx   (st_idx)
    );

    assign pick_grant = (|starved) ? st_grant : rr_grant;
    assign pick_idx   = (|starved) ? st_idx   : rr_idx;

    // Count cycles each entry waits while requesting; clear on grant or idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REQ; k++) age_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_i[k] || grant_o[k])
                    age_q[k] <= '0;
                else if (age_q[k] != AGE_MAX)
                    age_q[k] <= age_q[k] + AGE_W'(1);
            end
        end
    end
`else
    assign pick_grant = rr_grant;
    assign pick_idx   = rr_idx;
`endif

    assign grant_en      = !reset && (state_q == SCHED_READY) && fu_ready_i
                           && !flush_i && (|req_i);
    assign grant_o       = grant_en ? pick_grant : '0;
    assign grant_valid_o = |grant_o;
    assign grant_idx_o   = grant_en ? pick_idx : '0;
    assign busy_o        = !reset && (state_q == SCHED_BUSY);
    assign occ           = eff_lat(lat_i[int'(pick_idx)*LAT_W +: LAT_W]);

    // Occupancy FSM and rotating pointer; flush aborts occupancy only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCHED_READY;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            state_q <= SCHED_READY;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                SCHED_READY: begin
                    if (grant_valid_o) begin
                        ptr_q <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0
                                                                 : pick_idx + IDX_W'(1);
                        if (occ > LAT_W'(LAT_ONE)) begin
                            state_q <= SCHED_BUSY;
                            cnt_q   <= occ - LAT_W'(1);
                        end
                    end
                end
                SCHED_BUSY: begin
                    cnt_q <= cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) state_q <= SCHED_READY;
                end
                default: begin
                    state_q <= SCHED_READY;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_select_scheduler.sv
// Directed bench for issue_select_scheduler (aging case under SELECT_AGING_EN).
module tb_issue_select_scheduler;

    localparam int NUM_REQ = 16;
    localparam int LAT_W   = 3;
`ifdef SELECT_AGING_EN
    localparam int AGE_W   = 2;
`else
    localparam int AGE_W   = 4;
`endif
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LAT_W-1:0] lat;
    logic                     fu_ready;
    logic                     flush;
    logic [NUM_REQ-1:0]       grant;
    logic                     grant_valid;
    logic [IDX_W-1:0]         grant_idx;
    logic                     busy;

    int n_tests = 0;
    int n_fail  = 0;

    issue_select_scheduler #(
        .NUM_REQ (NUM_REQ),
        .LAT_W   (LAT_W),
        .AGE_W   (AGE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req),
        .lat_i         (lat),
        .fu_ready_i    (fu_ready),
        .flush_i       (flush),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_lat(input int k, input logic [LAT_W-1:0] v);
        lat[k*LAT_W +: LAT_W] = v;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 16'hFFFF;
        fu_ready = 1'b1;
        flush    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) lat[k*LAT_W +: LAT_W] = 3'd1;

        // Reset state
        tick(); tick();
        settle();
        check("rst_valid", 32'(grant_valid), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_idx",   32'(grant_idx), 0);
        check("rst_busy",  32'(busy), 0);

        // Fairness: full request vector walks 0..15 then wraps
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            check($sformatf("fair_idx%0d", i), 32'(grant_idx), i % 16);
            check($sformatf("fair_oh%0d", i), 32'(grant), 32'(1) << (i % 16));
            tick();
        end

        // Sparse wrap: 0,15,0,15,...
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 16'h8001;
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("wrap_idx%0d", i), 32'(grant_idx), (i % 2) ? 15 : 0);
            check($sformatf("wrap_vld%0d", i), 32'(grant_valid), 1);
            tick();
        end

        // Multi-cycle occupancy: lat[1]=3 blocks two cycles, then entry 2
        req = 16'h0006;
        set_lat(1, 3'd3);
        settle();
        check("mc_t0_idx", 32'(grant_idx), 1);
        check("mc_t0_vld", 32'(grant_valid), 1);
        tick(); settle();
        check("mc_t1_busy", 32'(busy), 1);
        check("mc_t1_vld",  32'(grant_valid), 0);
        tick(); settle();
        check("mc_t2_busy", 32'(busy), 1);
        check("mc_t2_vld",  32'(grant_valid), 0);
        tick(); settle();
        check("mc_t3_busy", 32'(busy), 0);
        check("mc_t3_idx",  32'(grant_idx), 2);
        check("mc_t3_vld",  32'(grant_valid), 1);
        tick();

        // Occupancy 0 behaves as 1: ptr=3 wraps to entry 1, then entry 2 next cycle
        set_lat(1, 3'd0);
        settle();
        check("lat0_t0_idx", 32'(grant_idx), 1);
        tick(); settle();
        check("lat0_t1_busy", 32'(busy), 0);
        check("lat0_t1_idx",  32'(grant_idx), 2);
        check("lat0_t1_vld",  32'(grant_valid), 1);
        tick();
        set_lat(1, 3'd1);

        // Back-pressure: no grants while FU not ready, grant on return
        req      = 16'h0010;
        fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp_vld%0d", i), 32'(grant_valid), 0);
            tick();
        end
        fu_ready = 1'b1;
        settle();
        check("bp_ret_idx", 32'(grant_idx), 4);
        check("bp_ret_vld", 32'(grant_valid), 1);
        tick();

        // Flush during BUSY with cnt=2: grant possible right after
        req = 16'h0020;
        set_lat(5, 3'd3);
        settle();
        check("fl_grant_idx", 32'(grant_idx), 5);
        tick();
        flush = 1'b1;
        settle();
        check("fl_cycle_busy", 32'(busy), 1);
        check("fl_cycle_vld",  32'(grant_valid), 0);
        tick();
        flush = 1'b0;
        settle();
        check("fl_after_busy", 32'(busy), 0);
        check("fl_after_vld",  32'(grant_valid), 1);
        check("fl_after_idx",  32'(grant_idx), 5);
        tick();
        req = '0;
        settle(); check("fl_rebusy1", 32'(busy), 1);
        tick();
        settle(); check("fl_rebusy2", 32'(busy), 1);
        tick();
        set_lat(5, 3'd1);

        // Reset mid-BUSY with ptr=7
        set_lat(6, 3'd3);
        req = 16'h0040;
        settle();
        check("rm_grant_idx", 32'(grant_idx), 6);
        tick();
        settle();
        check("rm_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        req   = 16'hFFFF;
        settle();
        check("rm_rst_busy", 32'(busy), 0);
        check("rm_rst_vld",  32'(grant_valid), 0);
        tick();
        reset = 1'b0;
        set_lat(6, 3'd1);
        settle();
        check("rm_post_busy", 32'(busy), 0);
        check("rm_post_idx",  32'(grant_idx), 0);
        check("rm_post_vld",  32'(grant_valid), 1);
        tick();

`ifdef SELECT_AGING_EN
        // Aging: entry 3 waits behind a 3-cycle op, then beats entry 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 16'h0009;
        set_lat(0, 3'd3);
        settle();
        check("age_c1_idx", 32'(grant_idx), 0);
        tick();
        settle(); check("age_c2_busy", 32'(busy), 1);
        tick();
        settle(); check("age_c3_busy", 32'(busy), 1);
        tick();
        req = 16'h000A;
        set_lat(0, 3'd1);
        settle();
        check("age_c4_idx", 32'(grant_idx), 3);
        check("age_c4_vld", 32'(grant_valid), 1);
        tick();
        settle();
        check("age_c5_age3", 32'(dut.age_q[3]), 0);
        check("age_c5_idx",  32'(grant_idx), 1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
